// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared widths, constants and entry type for the writeback queue
package writeback_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// rtl/wbq_match.sv - youngest-match search over pending writeback entries
//
// Purpose: given the entry array and the live window [head, head+count),
// reports whether any live entry targets addr and returns the data of the
// youngest such entry. Register 0 never matches.
// Ports:
//   entries  - queue storage, indexed by slot
//   head     - slot of the oldest live entry
//   count    - number of live entries
//   addr     - register address to look up
//   hit      - a live entry targets addr
//   data     - data of the youngest matching entry, 0 on a miss
module wbq_match
    import writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                    entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [$clog2(DEPTH):0]       count,
    input  logic [ADDR_W-1:0]            addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin : search
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr != ZERO_REG) && (entries[idx].addr == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - dual-producer register-file write buffer with optional forwarding
//
// Purpose: accepts up to two register writes per cycle (load stage and ALU
// stage), stores them in a circular FIFO and drains one per cycle into the
// register file write port. Optional macro WBQ_FWD_EN compiles in forwarding
// of pending data to two read ports; without it the fwd outputs are tied to 0.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   mem_valid/addr/data, mem_ready  - load-stage write request
//   alu_valid/addr/data, alu_ready  - ALU-stage write request
//   wb_we, wb_addr, wb_data         - register file write port
//   fwd0/1_addr                     - read addresses to look up
//   fwd0/1_hit, fwd0/1_data         - pending-data forwarding results
module writeback_queue
    import writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] fwd0_addr,
    input  logic [ADDR_W-1:0] fwd1_addr,
    output logic              fwd0_hit,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd0_data,
    output logic [DATA_W-1:0] fwd1_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       entries [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            non_empty;
    logic            mem_store;
    logic            alu_store;
    logic [1:0]      enq_n;
    logic [PW-1:0]   alu_slot;

    assign non_empty = (count != '0);

    // Readiness looks only at the registered count; the pop happening this
    // cycle is deliberately not credited so ready never depends on wb_we.
    assign mem_ready = (count <= CW'(DEPTH - 1));
    assign alu_ready = (count <= CW'(DEPTH - 2)) ||
                       ((count == CW'(DEPTH - 1)) && !mem_valid);

    // Writes to register 0 are acknowledged but never occupy a slot.
    assign mem_store = mem_valid && mem_ready && (mem_addr != ZERO_REG);
    assign alu_store = alu_valid && alu_ready && (alu_addr != ZERO_REG);
    assign enq_n     = {1'b0, mem_store} + {1'b0, alu_store};

    // The mem entry is older in program order, so the ALU entry goes behind it.
    assign alu_slot  = tail + PW'(mem_store);

    assign wb_we   = non_empty;
    assign wb_addr = non_empty ? entries[head].addr : '0;
    assign wb_data = non_empty ? entries[head].data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (mem_store) begin
                entries[tail] <= '{addr: mem_addr, data: mem_data};
            end
            if (alu_store) begin
                entries[alu_slot] <= '{addr: alu_addr, data: alu_data};
            end
            tail  <= tail + PW'(enq_n);
            head  <= head + PW'(non_empty);
            count <= count + CW'(enq_n) - CW'(non_empty);
        end
    end

`ifdef WBQ_FWD_EN
    wbq_match #(.DEPTH(DEPTH)) u_match0 (
        .entries (entries),
        .head    (head),
        .count   (count),
        .addr    (fwd0_addr),
        .hit     (fwd0_hit),
        .data    (fwd0_data)
    );

    wbq_match #(.DEPTH(DEPTH)) u_match1 (
        .entries (entries),
        .head    (head),
        .count   (count),
        .addr    (fwd1_addr),
        .hit     (fwd1_hit),
        .data    (fwd1_data)
    );
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd0_addr, fwd1_addr};

    assign fwd0_hit  = 1'b0;
    assign fwd1_hit  = 1'b0;
    assign fwd0_data = '0;
    assign fwd1_data = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed self-checking bench for writeback_queue
module tb_writeback_queue;

`ifdef WBQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid;
    logic [4:0]  mem_addr, alu_addr;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  fwd0_addr, fwd1_addr;
    logic        fwd0_hit, fwd1_hit;
    logic [31:0] fwd0_data, fwd1_data;

    int tests = 0;
    int fails = 0;

    logic [36:0] mq[$];

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .fwd0_addr (fwd0_addr),
        .fwd1_addr (fwd1_addr),
        .fwd0_hit  (fwd0_hit),
        .fwd1_hit  (fwd1_hit),
        .fwd0_data (fwd0_data),
        .fwd1_data (fwd1_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle against the queue model: drive at negedge, check 1ns later,
    // then update the model with what the DUT should accept and pop.
    task automatic step(input bit mv, input logic [4:0] ma, input logic [31:0] md,
                        input bit av, input logic [4:0] aa, input logic [31:0] ad);
        int  n;
        bit  emr, ear;
        @(negedge clk);
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        #1;
        n   = mq.size();
        emr = (n <= 3);
        ear = (n <= 2) || (n == 3 && !mv);
        check("step_mem_ready", mem_ready, emr);
        check("step_alu_ready", alu_ready, ear);
        check("step_wb_we", wb_we, n != 0);
        check("step_count", dut.count, n);
        if (n != 0) begin
            check("step_wb_addr", wb_addr, mq[0][36:32]);
            check("step_wb_data", wb_data, mq[0][31:0]);
            void'(mq.pop_front());
        end
        if (mv && emr && ma != 0) mq.push_back({ma, md});
        if (av && ear && aa != 0) mq.push_back({aa, ad});
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        fwd0_addr = 0; fwd1_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_mem_ready", mem_ready, 1);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_fwd0_hit", fwd0_hit, 0);
        check("rst_fwd1_hit", fwd1_hit, 0);
        check("rst_count", dut.count, 0);

        // Single ALU write: visible on wb_* the next cycle, gone the one after.
        @(negedge clk);
        alu_valid = 1; alu_addr = 5'd3; alu_data = 32'hDEADBEEF; fwd0_addr = 5'd3;
        #1;
        check("s1_alu_ready", alu_ready, 1);
        check("s1_wb_we_before", wb_we, 0);
        @(negedge clk);
        alu_valid = 0;
        #1;
        check("s1_wb_we", wb_we, 1);
        check("s1_wb_addr", wb_addr, 3);
        check("s1_wb_data", wb_data, 32'hDEADBEEF);
        check("s1_fwd0_hit", fwd0_hit, FWD);
        check("s1_fwd0_data", fwd0_data, FWD ? 32'hDEADBEEF : 32'h0);
        @(negedge clk);
        #1;
        check("s1_wb_we_after", wb_we, 0);
        check("s1_fwd0_hit_after", fwd0_hit, 0);

        // Both producers to r5: mem drains first, forwarding returns the ALU value.
        @(negedge clk);
        mem_valid = 1; mem_addr = 5'd5; mem_data = 32'h11;
        alu_valid = 1; alu_addr = 5'd5; alu_data = 32'h22;
        fwd0_addr = 5'd5; fwd1_addr = 5'd7;
        #1;
        check("s2_mem_ready", mem_ready, 1);
        check("s2_alu_ready", alu_ready, 1);
        @(negedge clk);
        mem_valid = 0; alu_valid = 0;
        #1;
        check("s2_first_we", wb_we, 1);
        check("s2_first_addr", wb_addr, 5);
        check("s2_first_data", wb_data, 32'h11);
        check("s2_fwd0_hit_both", fwd0_hit, FWD);
        check("s2_fwd0_data_both", fwd0_data, FWD ? 32'h22 : 32'h0);
        check("s2_fwd1_hit_miss", fwd1_hit, 0);
        check("s2_fwd1_data_miss", fwd1_data, 0);
        @(negedge clk);
        #1;
        check("s2_second_we", wb_we, 1);
        check("s2_second_data", wb_data, 32'h22);
        check("s2_fwd0_hit_one", fwd0_hit, FWD);
        check("s2_fwd0_data_one", fwd0_data, FWD ? 32'h22 : 32'h0);
        @(negedge clk);
        #1;
        check("s2_drained_we", wb_we, 0);
        check("s2_fwd0_hit_empty", fwd0_hit, 0);

        // Write to r0 is acknowledged and dropped.
        @(negedge clk);
        alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF; fwd0_addr = 5'd0;
        #1;
        check("s3_alu_ready", alu_ready, 1);
        @(negedge clk);
        alu_valid = 0;
        #1;
        check("s3_wb_we", wb_we, 0);
        check("s3_fwd0_hit", fwd0_hit, 0);
        check("s3_count", dut.count, 0);

        // Sustained dual traffic against the queue model.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 5'(1 + (2 * i) % 31), 32'h1000 + i, 1'b1, 5'(2 + (2 * i) % 29), 32'h2000 + i);
        end
        // ALU alone at count 3 is accepted; r0 on the mem side is dropped.
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h3000);
        step(1'b1, 5'd0, 32'h3001, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        end
        check("s4_drained", mq.size(), 0);

        // Fill, then reset with requests present: everything is discarded.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'(10 + i), 32'h4000 + i, 1'b1, 5'(20 + i), 32'h5000 + i);
        end
        check("s5_filled", dut.count, 3);
        @(negedge clk);
        rst = 1'b1;
        mem_valid = 1; mem_addr = 5'd4; mem_data = 32'h6000;
        alu_valid = 1; alu_addr = 5'd6; alu_data = 32'h6001;
        @(negedge clk);
        rst = 1'b0;
        mem_valid = 0; alu_valid = 0;
        mq.delete();
        #1;
        check("s5_wb_we", wb_we, 0);
        check("s5_count", dut.count, 0);
        check("s5_mem_ready", mem_ready, 1);
        check("s5_alu_ready", alu_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
